// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: PC link, instruction-memory read port and decoder handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              pc_up;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    input  address, mem_ack, mem_data, instr_ready,
    output pc_up, mem_rd, mem_addr, instr, instr_valid
  );

  modport slave (
    output address, mem_ack, mem_data, instr_ready,
    input  pc_up, mem_rd, mem_addr, instr, instr_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch controller: reads the word at the current PC, hands it to the decoder,
// pulses the PC increment once per fetch, and traps in ERROR if memory never acknowledges.
module instruction_fetch #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                halt,
  output logic                fetch_err,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StError} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              pc_up_q, pc_up_d;
  logic              fetch_err_q, fetch_err_d;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_up_q       <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_up_q       <= pc_up_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_rd_d      = mem_rd_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_up_d       = 1'b0;
    fetch_err_d   = fetch_err_q;

    unique case (state_q)
      StIdle: begin
        if (!halt) begin
          mem_addr_d = bus.address;
          mem_rd_d   = 1'b1;
          cnt_d      = '0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        // An ack on the final permitted cycle still completes the fetch.
        if (bus.mem_ack) begin
          instr_d       = bus.mem_data;
          instr_valid_d = 1'b1;
          pc_up_d       = 1'b1;
          mem_rd_d      = 1'b0;
          state_d       = StHold;
        end else if (cnt_q == TimeoutLast) begin
          mem_rd_d    = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = StError;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        // Always pass through IDLE so the next address is sampled after the PC update.
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = StIdle;
        end
      end
      StError: begin
        mem_rd_d      = 1'b0;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.pc_up       = pc_up_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign fetch_err       = fetch_err_q;

endmodule
